// File: rtl/writeback_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_if
// Description : Upstream result, register-file, data-RAM store and PC-load
//               signal bundle for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_stage_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              valid_in;
    logic              ready_out;
    logic              store;
    logic              branch;
    logic [ADDR_W-1:0] dst_reg;
    logic [31:0]       mem_addr_in;
    logic [31:0]       GPR;
    logic [31:0]       RAM;
    logic [31:0]       PC;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [31:0]       rf_wdata;

    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    logic              pc_load;
    logic [31:0]       pc_value;

    logic              err_timeout;
    logic [CNT_W-1:0]  retire_count;

    // Upstream / environment side
    modport master (
        output valid_in, store, branch, dst_reg, mem_addr_in, GPR, RAM, PC,
        output mem_ack,
        input  ready_out, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr,
        input  mem_wdata, pc_load, pc_value, err_timeout, retire_count
    );

    // Writeback stage side
    modport slave (
        input  valid_in, store, branch, dst_reg, mem_addr_in, GPR, RAM, PC,
        input  mem_ack,
        output ready_out, rf_we, rf_waddr, rf_wdata, mem_req, mem_addr,
        output mem_wdata, pc_load, pc_value, err_timeout, retire_count
    );
endinterface
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Commits a routed result to the register file, data RAM or PC,
//               stalls during stores, enforces a store timeout, counts retires.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    localparam int              TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        STORE_WAIT = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [TMR_W-1:0]  timer, timer_n;

    logic              rf_we, rf_we_n;
    logic [ADDR_W-1:0] rf_waddr, rf_waddr_n;
    logic [31:0]       rf_wdata, rf_wdata_n;

    logic              mem_req, mem_req_n;
    logic [31:0]       mem_addr, mem_addr_n;
    logic [31:0]       mem_wdata, mem_wdata_n;

    logic              pc_load, pc_load_n;
    logic [31:0]       pc_value, pc_value_n;

    logic              err_timeout, err_timeout_n;
    logic [CNT_W-1:0]  retire_count, retire_count_n;

    logic              accept;
    logic              is_store;
    logic              is_branch;

    assign accept    = bus.valid_in && (state == IDLE);
    // Both flags set is not a legal store or branch; it falls back to a GPR write.
    assign is_store  = bus.store && !bus.branch;
    assign is_branch = bus.branch && !bus.store;

    always_comb begin
        state_n        = state;
        timer_n        = timer;
        rf_we_n        = 1'b0;
        rf_waddr_n     = rf_waddr;
        rf_wdata_n     = rf_wdata;
        mem_req_n      = mem_req;
        mem_addr_n     = mem_addr;
        mem_wdata_n    = mem_wdata;
        pc_load_n      = 1'b0;
        pc_value_n     = pc_value;
        err_timeout_n  = err_timeout;
        retire_count_n = retire_count;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_store) begin
                        mem_addr_n  = bus.mem_addr_in;
                        mem_wdata_n = bus.RAM;
                        mem_req_n   = 1'b1;
                        timer_n     = TMR_W'(1);
                        state_n     = STORE_WAIT;
                    end else if (is_branch) begin
                        pc_load_n      = 1'b1;
                        pc_value_n     = bus.PC;
                        retire_count_n = retire_count + CNT_W'(1);
                    end else begin
                        // r0 is hard-wired zero: skip the strobe but still retire
                        rf_we_n        = (bus.dst_reg != '0);
                        rf_waddr_n     = bus.dst_reg;
                        rf_wdata_n     = bus.GPR;
                        retire_count_n = retire_count + CNT_W'(1);
                    end
                end
            end

            STORE_WAIT: begin
                if (bus.mem_ack) begin
                    mem_req_n      = 1'b0;
                    timer_n        = '0;
                    retire_count_n = retire_count + CNT_W'(1);
                    state_n        = IDLE;
                end else if (timer == TMR_LIMIT) begin
                    mem_req_n     = 1'b0;
                    timer_n       = '0;
                    err_timeout_n = 1'b1;
                    state_n       = IDLE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            default: begin
                state_n   = IDLE;
                mem_req_n = 1'b0;
                timer_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer        <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            pc_load      <= 1'b0;
            pc_value     <= '0;
            err_timeout  <= 1'b0;
            retire_count <= '0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            rf_we        <= rf_we_n;
            rf_waddr     <= rf_waddr_n;
            rf_wdata     <= rf_wdata_n;
            mem_req      <= mem_req_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            pc_load      <= pc_load_n;
            pc_value     <= pc_value_n;
            err_timeout  <= err_timeout_n;
            retire_count <= retire_count_n;
        end
    end

    assign bus.ready_out    = (state == IDLE);
    assign bus.rf_we        = rf_we;
    assign bus.rf_waddr     = rf_waddr;
    assign bus.rf_wdata     = rf_wdata;
    assign bus.mem_req      = mem_req;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.pc_load      = pc_load;
    assign bus.pc_value     = pc_value;
    assign bus.err_timeout  = err_timeout;
    assign bus.retire_count = retire_count;

endmodule
`default_nettype wire
